// File: rtl/led_pkg.sv
// Shared constants for the LED fader: colour codes, channel indices, FSM states.
package led_pkg;
  localparam logic [2:0] COLOUR_OFF = 3'b000;
  localparam logic [2:0] COLOUR_ALL = 3'b111;

  localparam int RED   = 0;
  localparam int GREEN = 1;
  localparam int BLUE  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_e;
endpackage

// File: rtl/fade_channel.sv
// One PWM channel: target register, saturating linear fade of the duty
// toward the target once per period, and a registered PWM compare.
module fade_channel #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [PWM_BITS-1:0] level,
  input  logic                boundary,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                led,
  output logic                match
);
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(STEP);

  logic [PWM_BITS-1:0] target, duty, duty_next;
  logic [PWM_BITS:0]   tgt_w, duty_w, diff;

  // Extra bit keeps duty+STEP from wrapping before the clamp to target.
  always_comb begin
    tgt_w     = {1'b0, target};
    duty_w    = {1'b0, duty};
    diff      = '0;
    duty_next = duty;
    if (tgt_w >= duty_w) begin
      diff      = tgt_w - duty_w;
      duty_next = (diff <= STEP_W) ? target : PWM_BITS'(duty_w + STEP_W);
    end else begin
      diff      = duty_w - tgt_w;
      duty_next = (diff <= STEP_W) ? target : PWM_BITS'(duty_w - STEP_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      duty   <= '0;
      led    <= 1'b0;
    end else begin
      if (load)     target <= en ? level : '0;
      if (boundary) duty   <= duty_next;
      led <= (duty > cnt);
    end
  end

  assign match = (duty == target);
endmodule

// File: rtl/led_fader.sv
// RGB PWM driver that cross-fades each channel toward the sampled colour,
// flags rejected codes and reports fade activity.
module led_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          colour,
  input  logic [PWM_BITS-1:0] level,
  output logic [2:0]          led,
  output logic                busy,
  output logic                illegal
);
  logic [PWM_BITS-1:0] cnt;
  logic                boundary, legal;
  logic [2:0]          led_ch, match;
  fade_state_e         state, state_next;

  assign boundary = &cnt;
  assign legal    = (colour != COLOUR_OFF) && (colour != COLOUR_ALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      illegal <= 1'b0;
      state   <= IDLE;
    end else begin
      cnt     <= cnt + 1'b1;
      illegal <= !legal;
      state   <= state_next;
    end
  end

  // Duties only move on boundaries, so a full match in FADE implies the
  // last boundary update landed every channel on its target.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!(&match)) state_next = FADE;
      FADE:    if (&match)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == FADE);

  for (genvar c = 0; c < 3; c++) begin : g_ch
    fade_channel #(.PWM_BITS(PWM_BITS), .STEP(STEP)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (legal),
      .en       (colour[c]),
      .level    (level),
      .boundary (boundary),
      .cnt      (cnt),
      .led      (led_ch[c]),
      .match    (match[c])
    );
  end

  assign led = {led_ch[BLUE], led_ch[GREEN], led_ch[RED]};
endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with a 16-clock PWM period and STEP of 4.
module tb_led_fader;
  localparam int PW = 4;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    colour;
  logic [PW-1:0] level;
  logic [2:0]    led;
  logic          busy, illegal;

  int vecs = 0;
  int errs = 0;
  int edges = 0;
  int ones;
  logic [1:0] gb;

  led_fader #(.PWM_BITS(PW), .STEP(ST)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .colour  (colour),
    .level   (level),
    .led     (led),
    .busy    (busy),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Edge k after release is a period boundary when k is a multiple of 16.
  task automatic wait_bnd();
    do tick(); while (edges % 16 != 0);
  endtask

  initial begin
    rst_n = 1'b0; colour = 3'b001; level = 4'd15;
    #2;
    check("rst_led", 32'(led), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_illegal", 32'(illegal), 0);
    @(negedge clk); rst_n = 1'b1; edges = 0;

    tick();     check("busy_e1", 32'(busy), 0);
    tick();     check("busy_e2", 32'(busy), 1);
    wait_bnd(); check("red_d4", 32'(dut.g_ch[0].u_ch.duty), 4);
    wait_bnd(); check("red_d8", 32'(dut.g_ch[0].u_ch.duty), 8);
    wait_bnd(); check("red_d12", 32'(dut.g_ch[0].u_ch.duty), 12);
    wait_bnd(); check("red_d15", 32'(dut.g_ch[0].u_ch.duty), 15);
    check("busy_last_bnd", 32'(busy), 1);
    tick();     check("busy_done", 32'(busy), 0);

    ones = 0; gb = 2'b00;
    repeat (16) begin
      tick();
      ones += int'(led[0]);
      gb |= led[2:1];
    end
    check("steady_red_ones", 32'(ones), 15);
    check("steady_gb", 32'(gb), 0);
    check("steady_busy", 32'(busy), 0);

    colour = 3'b111; tick(); check("illegal_111", 32'(illegal), 1);
    colour = 3'b000; tick(); check("illegal_000", 32'(illegal), 1);
    colour = 3'b001; tick(); check("illegal_clear", 32'(illegal), 0);
    check("ill_red_tgt", 32'(dut.g_ch[0].u_ch.target), 15);
    check("ill_red_duty", 32'(dut.g_ch[0].u_ch.duty), 15);
    check("ill_busy", 32'(busy), 0);

    wait_bnd(); level = 4'd6;
    wait_bnd(); check("lvl_d11", 32'(dut.g_ch[0].u_ch.duty), 11);
    check("lvl_busy", 32'(busy), 1);
    wait_bnd(); check("lvl_d7", 32'(dut.g_ch[0].u_ch.duty), 7);
    wait_bnd(); check("lvl_d6", 32'(dut.g_ch[0].u_ch.duty), 6);
    wait_bnd(); check("lvl_hold6", 32'(dut.g_ch[0].u_ch.duty), 6);
    check("lvl_idle", 32'(busy), 0);

    level = 4'd15;
    wait_bnd(); check("pre_rst_d10", 32'(dut.g_ch[0].u_ch.duty), 10);
    check("pre_rst_busy", 32'(busy), 1);
    repeat (3) tick();
    #4 rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_illegal", 32'(illegal), 0);
    check("arst_duty", 32'(dut.g_ch[0].u_ch.duty), 0);
    @(negedge clk); rst_n = 1'b1; edges = 0;

    wait_bnd(); check("restart_d4", 32'(dut.g_ch[0].u_ch.duty), 4);
    wait_bnd(); check("restart_d8", 32'(dut.g_ch[0].u_ch.duty), 8);
    colour = 3'b010;
    wait_bnd();
    check("rt_red4", 32'(dut.g_ch[0].u_ch.duty), 4);
    check("rt_grn4", 32'(dut.g_ch[1].u_ch.duty), 4);
    wait_bnd();
    check("rt_red0", 32'(dut.g_ch[0].u_ch.duty), 0);
    check("rt_grn8", 32'(dut.g_ch[1].u_ch.duty), 8);
    check("rt_busy", 32'(busy), 1);
    wait_bnd(); check("rt_grn12", 32'(dut.g_ch[1].u_ch.duty), 12);
    wait_bnd(); check("rt_grn15", 32'(dut.g_ch[1].u_ch.duty), 15);
    check("rt_busy_last", 32'(busy), 1);
    tick();
    check("rt_idle", 32'(busy), 0);
    check("rt_blue_duty", 32'(dut.g_ch[2].u_ch.duty), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
